// File: rtl/scratchpad_responder_if.sv
// Request/response bundle between an initiator and the scratchpad responder.
// The initiator drives the request strobes; the responder drives ready pulses, data and status.
interface scratchpad_responder_if #(
    parameter int unsigned DATA_WID = 32
);
    logic                read_enable;
    logic [63:0]         read_addr;
    logic [63:0]         read_size;
    logic                finish_read;
    logic                write_enable;
    logic [63:0]         write_addr;
    logic [DATA_WID-1:0] write_data;
    logic [63:0]         write_size;
    logic                finish_write;

    logic [63:0]         read_ready;
    logic [DATA_WID-1:0] read_data;
    logic [63:0]         write_ready;
    logic                busy;
    logic                err_overlap;
    logic [31:0]         rd_count;
    logic [31:0]         wr_count;

    modport master (
        output read_enable, read_addr, read_size, finish_read,
        output write_enable, write_addr, write_data, write_size, finish_write,
        input  read_ready, read_data, write_ready, busy, err_overlap, rd_count, wr_count
    );

    modport slave (
        input  read_enable, read_addr, read_size, finish_read,
        input  write_enable, write_addr, write_data, write_size, finish_write,
        output read_ready, read_data, write_ready, busy, err_overlap, rd_count, wr_count
    );
endinterface

// File: rtl/scratchpad_responder.sv
// Fixed-latency word scratchpad: one outstanding transaction, ready pulses after LATENCY cycles.
// A simultaneous read+write serves the write first, then runs a full-latency read.
module scratchpad_responder #(
    parameter int unsigned ADDR_WID = 14,
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned LATENCY  = 4
) (
    input logic                    clk,
    input logic                    reset,
    scratchpad_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WID;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam bit LAT_ONE = (LATENCY == 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP,
        WR_THEN_RD
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_WID-1:0] rd_idx_q;
    logic [ADDR_WID-1:0] wr_idx_q;
    logic [DATA_WID-1:0] wr_data_q;
    logic                pend_rd_q;
    logic                read_ready_q;
    logic                write_ready_q;
    logic [DATA_WID-1:0] read_data_q;
    logic                busy_q;
    logic                err_q;
    logic [31:0]         rd_count_q;
    logic [31:0]         wr_count_q;

    logic [DATA_WID-1:0] mem [DEPTH];

    logic [ADDR_WID-1:0] req_rd_idx;
    logic [ADDR_WID-1:0] req_wr_idx;
    logic                mem_we;
    logic                ready_cycle;

    assign req_rd_idx  = bus.read_addr[ADDR_WID+1:2];
    assign req_wr_idx  = bus.write_addr[ADDR_WID+1:2];
    assign ready_cycle = read_ready_q | write_ready_q;
    // Commit happens on the edge that leaves WR_RESP; a reset on that edge aborts it.
    assign mem_we      = (state_q == WR_RESP) && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx_q] <= wr_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_idx_q      <= '0;
            wr_idx_q      <= '0;
            wr_data_q     <= '0;
            pend_rd_q     <= 1'b0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            read_data_q   <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Strobes landing in a ready cycle are dropped without flagging overlap.
                    if (!ready_cycle) begin
                        if (bus.write_enable) begin
                            wr_idx_q  <= req_wr_idx;
                            wr_data_q <= bus.write_data;
                            rd_idx_q  <= req_rd_idx;
                            pend_rd_q <= bus.read_enable;
                            cnt_q     <= LAT_M1;
                            state_q   <= LAT_ONE ? WR_RESP : WR_WAIT;
                            busy_q    <= 1'b1;
                        end else if (bus.read_enable) begin
                            rd_idx_q  <= req_rd_idx;
                            cnt_q     <= LAT_M1;
                            state_q   <= LAT_ONE ? RD_RESP : RD_WAIT;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    read_ready_q <= 1'b1;
                    read_data_q  <= mem[rd_idx_q];
                    rd_count_q   <= rd_count_q + 32'd1;
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                end
                WR_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    write_ready_q <= 1'b1;
                    wr_count_q    <= wr_count_q + 32'd1;
                    pend_rd_q     <= 1'b0;
                    if (pend_rd_q) begin
                        state_q <= WR_THEN_RD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                WR_THEN_RD: begin
                    cnt_q   <= LAT_M1;
                    state_q <= LAT_ONE ? RD_RESP : RD_WAIT;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if ((state_q != IDLE) && (bus.read_enable || bus.write_enable)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.read_ready  = 64'(read_ready_q);
    assign bus.write_ready = 64'(write_ready_q);
    assign bus.read_data   = read_data_q;
    assign bus.busy        = busy_q;
    assign bus.err_overlap = err_q;
    assign bus.rd_count    = rd_count_q;
    assign bus.wr_count    = wr_count_q;

    // Sizes, finish markers and out-of-range address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{bus.read_size, bus.write_size, bus.finish_read, bus.finish_write,
                             bus.read_addr[63:ADDR_WID+2], bus.read_addr[1:0],
                             bus.write_addr[63:ADDR_WID+2], bus.write_addr[1:0]};
endmodule

// File: tb/tb_scratchpad_responder.sv
// Directed bench for scratchpad_responder: LATENCY=4 instance with a ready-pulse scoreboard,
// plus a LATENCY=1 instance checked cycle by cycle.
module tb_scratchpad_responder;
    localparam int unsigned LAT = 4;

    logic clk;
    logic reset;

    scratchpad_responder_if #(.DATA_WID(32)) ifa ();
    scratchpad_responder_if #(.DATA_WID(32)) ifb ();

    scratchpad_responder #(.ADDR_WID(14), .DATA_WID(32), .LATENCY(LAT)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ifa)
    );

    scratchpad_responder #(.ADDR_WID(6), .DATA_WID(32), .LATENCY(1)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [int unsigned];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned widx(input logic [63:0] a);
        return 32'(a[15:2]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ready pulse on instance A must match the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && (ifa.read_ready !== 64'd0 || ifa.write_ready !== 64'd0)) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_ready observed rd=0x%0h wr=0x%0h expected no pulse",
                       ifa.read_ready, ifa.write_ready);
            end
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check(mon_e.is_read ? "read_ready" : "write_ready",
                      mon_e.is_read ? ifa.read_ready : ifa.write_ready, 64'd1);
                check("other_ready", mon_e.is_read ? ifa.write_ready : ifa.read_ready, 64'd0);
                check("ready_cycle", 64'(cyc), 64'(mon_e.due));
                if (mon_e.is_read) check("read_data", 64'(ifa.read_data), 64'(mon_e.data));
            end
        end
    end

    task automatic issue(input bit rd, input logic [63:0] ra, input bit wr,
                         input logic [63:0] wa, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        ifa.read_enable  = rd;
        ifa.read_addr    = ra;
        ifa.write_enable = wr;
        ifa.write_addr   = wa;
        ifa.write_data   = wd;
        if (wr) begin
            model[widx(wa)] = wd;
            e.is_read = 1'b0;
            e.data    = wd;
            e.due     = cyc + 1 + LAT;
            sbq.push_back(e);
            exp_wr++;
        end
        if (rd) begin
            e.is_read = 1'b1;
            e.data    = model[widx(ra)];
            e.due     = wr ? cyc + 2 + 2 * LAT : cyc + 1 + LAT;
            sbq.push_back(e);
            exp_rd++;
        end
        @(negedge clk);
        ifa.read_enable  = 1'b0;
        ifa.write_enable = 1'b0;
    endtask

    // Strobe for one cycle without any expectation (dropped or aborted requests).
    task automatic raw_strobe(input bit rd, input bit wr, input logic [63:0] addr, input logic [31:0] wd);
        @(negedge clk);
        ifa.read_enable  = rd;
        ifa.read_addr    = addr;
        ifa.write_enable = wr;
        ifa.write_addr   = addr;
        ifa.write_data   = wd;
        @(negedge clk);
        ifa.read_enable  = 1'b0;
        ifa.write_enable = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        check(tag, 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ifa.read_enable = 1'b0;  ifa.read_addr = '0;  ifa.read_size = 64'd4;  ifa.finish_read = 1'b0;
        ifa.write_enable = 1'b0; ifa.write_addr = '0; ifa.write_data = '0;    ifa.write_size = 64'd4;
        ifa.finish_write = 1'b0;
        ifb.read_enable = 1'b0;  ifb.read_addr = '0;  ifb.read_size = 64'd4;  ifb.finish_read = 1'b0;
        ifb.write_enable = 1'b0; ifb.write_addr = '0; ifb.write_data = '0;    ifb.write_size = 64'd4;
        ifb.finish_write = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_read_ready", ifa.read_ready, 64'd0);
        check("rst_write_ready", ifa.write_ready, 64'd0);
        check("rst_read_data", 64'(ifa.read_data), 64'd0);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_err", 64'(ifa.err_overlap), 64'd0);
        check("rst_rd_count", 64'(ifa.rd_count), 64'd0);
        check("rst_wr_count", 64'(ifa.wr_count), 64'd0);
        check("rst_b_busy", 64'(ifb.busy), 64'd0);
        reset = 1'b0;

        // Write then read back at 0x40.
        issue(1'b0, 64'h0, 1'b1, 64'h40, 32'hDEADBEEF);
        check("busy_in_wait", 64'(ifa.busy), 64'd1);
        drain("drain_wr40");
        issue(1'b1, 64'h40, 1'b0, 64'h0, 32'h0);
        drain("drain_rd40");
        check("read_data_hold", 64'(ifa.read_data), 64'hDEADBEEF);

        // Same-cycle write and read: write first, then full-latency read.
        issue(1'b1, 64'h8, 1'b1, 64'h8, 32'h12345678);
        drain("drain_wr_rd");

        // Read strobe inside the write-ready cycle is dropped without overlap flag.
        issue(1'b0, 64'h0, 1'b1, 64'h20, 32'hA5A50001);
        repeat (3) @(negedge clk);
        raw_strobe(1'b1, 1'b0, 64'h20, 32'h0);
        repeat (8) @(negedge clk);
        check("ready_cycle_drop_err", 64'(ifa.err_overlap), 64'd0);
        check("ready_cycle_drop_busy", 64'(ifa.busy), 64'd0);
        check("drain_ready_drop", 64'(sbq.size()), 64'd0);

        // finish markers while idle have no effect.
        @(negedge clk);
        ifa.finish_read = 1'b1; ifa.finish_write = 1'b1;
        @(negedge clk);
        ifa.finish_read = 1'b0; ifa.finish_write = 1'b0;
        check("finish_idle_busy", 64'(ifa.busy), 64'd0);

        // Overlapping read two cycles after an accepted read.
        issue(1'b1, 64'h20, 1'b0, 64'h0, 32'h0);
        raw_strobe(1'b1, 1'b0, 64'h8, 32'h0);
        check("overlap_err", 64'(ifa.err_overlap), 64'd1);
        drain("drain_overlap");
        repeat (6) @(negedge clk);

        // Address wrap in depth.
        issue(1'b0, 64'h0, 1'b1, 64'h10000, 32'd7);
        drain("drain_wrap_wr");
        issue(1'b1, 64'h0, 1'b0, 64'h0, 32'h0);
        drain("drain_wrap_rd");
        check("rd_count", 64'(ifa.rd_count), 64'(exp_rd));
        check("wr_count", 64'(ifa.wr_count), 64'(exp_wr));

        // Reset during RD_WAIT aborts the read.
        @(negedge clk);
        ifa.read_enable = 1'b1; ifa.read_addr = 64'h40;
        @(negedge clk);
        ifa.read_enable = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_rd_ready", ifa.read_ready, 64'd0);
        check("abort_busy", 64'(ifa.busy), 64'd0);
        check("abort_rd_count", 64'(ifa.rd_count), 64'd0);
        check("abort_err", 64'(ifa.err_overlap), 64'd0);
        exp_rd = 0;
        exp_wr = 0;
        repeat (8) @(negedge clk);

        // Reset during WR_WAIT aborts the write; memory keeps its old contents.
        raw_strobe(1'b0, 1'b1, 64'h40, 32'h0BAD0BAD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(1'b1, 64'h40, 1'b0, 64'h0, 32'h0);
        drain("drain_after_reset");
        check("post_reset_rd_count", 64'(ifa.rd_count), 64'(exp_rd));
        check("post_reset_wr_count", 64'(ifa.wr_count), 64'd0);

        // LATENCY=1 instance: ready in the cycle after the edge following the strobe.
        @(negedge clk);
        ifb.write_enable = 1'b1; ifb.write_addr = 64'h4; ifb.write_data = 32'h00000055;
        @(negedge clk);
        ifb.write_enable = 1'b0;
        check("b_wr_ready_early", ifb.write_ready, 64'd0);
        check("b_busy", 64'(ifb.busy), 64'd1);
        @(negedge clk);
        check("b_wr_ready", ifb.write_ready, 64'd1);
        @(negedge clk);
        ifb.read_enable = 1'b1; ifb.read_addr = 64'h4;
        @(negedge clk);
        ifb.read_enable = 1'b0;
        check("b_rd_ready_early", ifb.read_ready, 64'd0);
        @(negedge clk);
        check("b_rd_ready", ifb.read_ready, 64'd1);
        check("b_read_data", 64'(ifb.read_data), 64'h55);
        @(negedge clk);
        check("b_rd_ready_single", ifb.read_ready, 64'd0);
        check("b_rd_count", 64'(ifb.rd_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
